if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a single-outstanding-request handshake on the instruction bus.
- Presents if_pc, if_inst and if_excepttype to IF/ID.
- Raises stallreq to the stall controller while a fetch is in flight.
- Applies branch redirects, exception flush redirects and fetch-address-misalignment exceptions.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- EXC_ADEL_BIT, 13, bit of if_excepttype set on a misaligned fetch address.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset (`RstEnable).
- stall  in  6  pipeline stall vector; stall[0]==`Stop holds the PC.
- flush  in  1  exception flush; redirect to new_pc.
- new_pc  in  32  exception handler / ERET target, used when flush==1.
- branch_flag_i  in  1  branch taken, from ID.
- branch_target_address_i  in  32  branch target, from ID.
- ibus_data_i  in  32  instruction read data.
- ibus_ack_i  in  1  bus acknowledge; data valid in the same cycle.
- ibus_req_o  out  1  bus request; held high until ack.
- ibus_addr_o  out  32  fetch address.
- if_pc  out  32  PC of the presented instruction.
- if_inst  out  32  presented instruction.
- if_excepttype  out  32  fetch exception bits; only EXC_ADEL_BIT is ever set.
- stallreq  out  1  fetch not complete; request to stall IF.

Behaviour:
- States:
  - START: one cycle after reset, no request.
  - FETCH: request outstanding.
  - READY: instruction held in buffer.
  - DRAIN: discarding a stale outstanding request.
- Reset (rst==1 at a clock edge, from any state, including mid-request):
  - pc<=RESET_PC, state<=START.
  - inst_buf<=0, exc_buf<=0.
  - ibus_req_o=0; if_pc/if_inst/if_excepttype=0; stallreq=0.
  - Reset abandons any outstanding bus transaction.
- START -> FETCH on the next cycle (if rst==0).
- FETCH:
  - stallreq=1; ibus_addr_o=pc.
  - If pc[1:0]==0: ibus_req_o=1. On ibus_ack_i: inst_buf<=ibus_data_i, exc_buf<=0, state<=READY.
  - If pc[1:0]!=0: ibus_req_o=0, no bus cycle. Next cycle inst_buf<=0, exc_buf[EXC_ADEL_BIT]<=1, state<=READY.
  - Minimum latency from entering FETCH to READY: 1 cycle (ack in the first FETCH cycle).
- READY:
  - stallreq=0; ibus_req_o=0.
  - if_pc=pc; if_inst=inst_buf; if_excepttype=exc_buf.
  - If stall[0]==`NoStop: pc<=branch_flag_i ? branch_target_address_i : pc+4 (32-bit wrap, carry dropped); state<=FETCH.
  - If stall[0]==`Stop: hold everything.
- Outputs outside READY: if_inst=0 and if_excepttype=0, but if_pc=pc still.
- flush==1 has priority over stall, branch and ack:
  - From READY, FETCH or START: pc<=new_pc.
  - FETCH with ibus_req_o==1 and no ack this cycle: state<=DRAIN.
  - FETCH with ack in the same cycle: state<=FETCH, returned data discarded.
  - Otherwise: state<=FETCH.
  - flush asserted while already in DRAIN: pc<=new_pc, state stays DRAIN.
- DRAIN:
  - ibus_req_o=1 with ibus_addr_o=the stale address, held in a registered addr_hold.
  - stallreq=1.
  - On ack: data discarded, state<=FETCH with the redirected pc.
- Bus protocol: ibus_addr_o is stable while ibus_req_o=1. Never more than one request outstanding. ibus_ack_i with ibus_req_o=0 is ignored.
- branch_flag_i is sampled only when READY advances. A branch outside that cycle is the controller's responsibility: the stall vector keeps ID stalled.

Test Plan:
- Reset, ack always high on the request cycle:
  - if_pc sequence 0,4,8,… each READY for one cycle.
  - stallreq pulses 1 for 1 cycle per instruction.
  - ibus_addr_o matches pc.
- Ack delayed 3 cycles at pc=0x10:
  - stallreq=1 for exactly 3 cycles, ibus_req_o and addr 0x10 stable throughout.
  - if_inst equals the data sampled on the ack cycle.
- READY at 0x20 with stall[0]=Stop for 4 cycles, then branch_flag_i=1, target 0x100:
  - if_pc stays 0x20 during the stall; next fetch address 0x100.
- flush=1, new_pc=0x80 while a request to 0x40 is outstanding:
  - req stays high at 0x40 until ack; that data never appears on if_inst.
  - Next request goes to 0x80.
- Branch target 0x102:
  - No bus request issued.
  - READY with if_pc=0x102, if_inst=0, if_excepttype=32'h00002000.
- rst asserted mid-request with pc=0x44:
  - Next cycle all outputs 0 and ibus_req_o=0.
  - Then START, then fetch of RESET_PC.
- pc=0xFFFFFFFC, READY advances with no branch: next pc=0x00000000.

Source files
------------

// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
// Instruction-bus handshake between the fetch stage and the instruction
// memory / bus bridge. One request outstanding at most; the address is held
// stable while ibus_req_o is high, and ibus_ack_i returns the data in the
// same cycle.
//
// Signals:
//   ibus_req_o   fetch -> bus   request, held high until ack
//   ibus_addr_o  fetch -> bus   32-bit fetch address
//   ibus_data_i  bus -> fetch   32-bit instruction data, valid with ack
//   ibus_ack_i   bus -> fetch   acknowledge
// Modports:
//   master  fetch-stage side
//   slave   memory / bus side
// ---------------------------------------------------------------------------
interface if_fetch_if;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic [31:0] ibus_data_i;
    logic        ibus_ack_i;

    modport master (
        output ibus_req_o,
        output ibus_addr_o,
        input  ibus_data_i,
        input  ibus_ack_i
    );

    modport slave (
        input  ibus_req_o,
        input  ibus_addr_o,
        output ibus_data_i,
        output ibus_ack_i
    );
endinterface

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC,
// runs a single-outstanding-request handshake on the instruction bus, and
// applies branch redirects, exception-flush redirects and fetch-address
// misalignment exceptions.
//
// Ports:
//   clk                      clock, rising edge
//   rst                      synchronous active-high reset
//   stall[5:0]               pipeline stall vector; stall[0] holds the PC
//   flush                    exception flush, redirect to new_pc
//   new_pc[31:0]             handler / ERET target used with flush
//   branch_flag_i            branch taken (from ID)
//   branch_target_address_i  branch target (from ID)
//   ibus                     instruction bus (master side)
//   if_pc[31:0]              PC of the presented instruction
//   if_inst[31:0]            presented instruction (0 unless READY)
//   if_excepttype[31:0]      fetch exception bits (0 unless READY)
//   stallreq                 fetch not complete, request IF stall
//
// Outputs are decoded purely from registered state (state, pc, buffers),
// never from inputs, so there is no combinational path from the bus or the
// pipeline controls to any output.
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned EXC_ADEL_BIT = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       stall,
    input  logic             flush,
    input  logic [31:0]      new_pc,
    input  logic             branch_flag_i,
    input  logic [31:0]      branch_target_address_i,
    if_fetch_if.master       ibus,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst,
    output logic [31:0]      if_excepttype,
    output logic             stallreq
);

    localparam int unsigned XLEN = 32;

    // FSM encoding
    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // stall[0] level that holds the PC
    localparam logic STOP = 1'b1;

    localparam logic [XLEN-1:0] PC_STEP       = XLEN'(4);
    localparam logic [XLEN-1:0] EXC_ADEL_MASK = XLEN'(1) << EXC_ADEL_BIT;

    // ------------------------------------------------------------------
    // State registers and their next values
    // ------------------------------------------------------------------
    logic [1:0]      state,     state_n;
    logic [XLEN-1:0] pc,        pc_n;
    logic [XLEN-1:0] inst_buf,  inst_buf_n;
    logic [XLEN-1:0] exc_buf,   exc_buf_n;
    logic [XLEN-1:0] addr_hold, addr_hold_n;

    // Bus-side combinational outputs before driving the interface
    logic            req_c;
    logic [XLEN-1:0] addr_c;
    logic            pc_aligned_c;

    // Only stall[0] concerns the fetch stage
    logic unused_stall;
    assign unused_stall = ^stall[5:1];

    assign pc_aligned_c = (pc[1:0] == 2'b00);

    // State register; reset also abandons any outstanding bus transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_START;
            pc        <= RESET_PC;
            inst_buf  <= '0;
            exc_buf   <= '0;
            addr_hold <= '0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            inst_buf  <= inst_buf_n;
            exc_buf   <= exc_buf_n;
            addr_hold <= addr_hold_n;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_n       = state;
        pc_n          = pc;
        inst_buf_n    = inst_buf;
        exc_buf_n     = exc_buf;
        addr_hold_n   = addr_hold;
        req_c         = 1'b0;
        addr_c        = pc;
        stallreq      = 1'b0;
        if_pc         = pc;
        if_inst       = '0;
        if_excepttype = '0;

        case (state)
            ST_START: begin
                state_n = ST_FETCH;
                if (flush) begin
                    pc_n = new_pc;
                end
            end

            ST_FETCH: begin
                stallreq    = 1'b1;
                req_c       = pc_aligned_c;
                // Remember the issued address in case a flush forces a drain
                addr_hold_n = pc;
                if (flush) begin
                    pc_n = new_pc;
                    // A request that has not been acked yet must be drained;
                    // an ack in this very cycle closes it and its data is dropped.
                    if (pc_aligned_c && !ibus.ibus_ack_i) begin
                        state_n = ST_DRAIN;
                    end else begin
                        state_n = ST_FETCH;
                    end
                end else if (!pc_aligned_c) begin
                    // Misaligned: no bus cycle, present an address-error exception
                    inst_buf_n = '0;
                    exc_buf_n  = EXC_ADEL_MASK;
                    state_n    = ST_READY;
                end else if (ibus.ibus_ack_i) begin
                    inst_buf_n = ibus.ibus_data_i;
                    exc_buf_n  = '0;
                    state_n    = ST_READY;
                end
            end

            ST_READY: begin
                if_inst       = inst_buf;
                if_excepttype = exc_buf;
                if (flush) begin
                    pc_n    = new_pc;
                    state_n = ST_FETCH;
                end else if (stall[0] != STOP) begin
                    pc_n    = branch_flag_i ? branch_target_address_i : pc + PC_STEP;
                    state_n = ST_FETCH;
                end
            end

            ST_DRAIN: begin
                // Keep the stale request alive at its original address until acked
                req_c    = 1'b1;
                addr_c   = addr_hold;
                stallreq = 1'b1;
                if (flush) begin
                    pc_n = new_pc;
                end
                // The ack closes the stale transaction even if a new flush arrives,
                // so no second request at the stale address is ever issued.
                if (ibus.ibus_ack_i) begin
                    state_n = ST_FETCH;
                end
            end

            default: begin
                state_n = ST_START;
            end
        endcase
    end

    assign ibus.ibus_req_o  = req_c;
    assign ibus.ibus_addr_o = addr_c;

endmodule
